// File: rtl/pattern_stream_generator.sv
// Serializes parallel words MSB-first onto a one-bit stream, alongside the
// 101/010 detector output a correct detector must produce for each bit.
module pattern_stream_generator #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             hist_clr,
   output logic             o,
   output logic             o_valid,
   output logic [1:0]       o_expect,
   output logic             done,
   output logic [CNT_W-1:0] cnt101,
   output logic [CNT_W-1:0] cnt010
);

   localparam int unsigned BCNT_W = $clog2(WIDTH);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t             r_state,  w_state;
   logic [WIDTH-1:0]   r_shift,  w_shift;
   logic [BCNT_W-1:0]  r_bitcnt, w_bitcnt;
   logic [1:0]         r_h,      w_h;
   logic [1:0]         r_hcnt,   w_hcnt;
   logic               r_o,      w_o;
   logic               r_o_valid, w_o_valid;
   logic [1:0]         r_expect, w_expect;
   logic               r_done,   w_done;
   logic [CNT_W-1:0]   r_cnt101, w_cnt101;
   logic [CNT_W-1:0]   r_cnt010, w_cnt010;

   logic               w_present;
   logic               w_bit;
   logic [1:0]         w_h_base;
   logic [1:0]         w_hcnt_base;

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bitcnt  <= '0;
         r_h       <= 2'b00;
         r_hcnt    <= 2'd0;
         r_o       <= 1'b0;
         r_o_valid <= 1'b0;
         r_expect  <= 2'b00;
         r_done    <= 1'b0;
         r_cnt101  <= '0;
         r_cnt010  <= '0;
      end else begin
         r_state   <= w_state;
         r_shift   <= w_shift;
         r_bitcnt  <= w_bitcnt;
         r_h       <= w_h;
         r_hcnt    <= w_hcnt;
         r_o       <= w_o;
         r_o_valid <= w_o_valid;
         r_expect  <= w_expect;
         r_done    <= w_done;
         r_cnt101  <= w_cnt101;
         r_cnt010  <= w_cnt010;
      end
   end

   // Next-state, serializer and reference-detector logic
   always_comb begin
      w_state     = r_state;
      w_shift     = r_shift;
      w_bitcnt    = r_bitcnt;
      w_h         = r_h;
      w_hcnt      = r_hcnt;
      w_o         = r_o;
      w_o_valid   = r_o_valid;
      w_expect    = r_expect;
      w_done      = 1'b0;
      w_cnt101    = r_cnt101;
      w_cnt010    = r_cnt010;
      w_present   = 1'b0;
      w_bit       = 1'b0;
      w_h_base    = r_h;
      w_hcnt_base = r_hcnt;

      case (r_state)
         S_IDLE: begin
            w_o       = 1'b0;
            w_o_valid = 1'b0;
            w_expect  = 2'b00;
            // Clear lands before the first bit of a same-edge handshake
            if (hist_clr) begin
               w_h_base    = 2'b00;
               w_hcnt_base = 2'd0;
               w_h         = 2'b00;
               w_hcnt      = 2'd0;
            end
            if (load_valid) begin
               w_present = 1'b1;
               w_bit     = load_data[WIDTH-1];
               w_shift   = {load_data[WIDTH-2:0], 1'b0};
               w_bitcnt  = BCNT_W'(WIDTH - 1);
               w_state   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_bitcnt == '0) begin
               w_o       = 1'b0;
               w_o_valid = 1'b0;
               w_expect  = 2'b00;
               w_done    = 1'b1;
               w_state   = S_IDLE;
            end else begin
               w_present = 1'b1;
               w_bit     = r_shift[WIDTH-1];
               w_shift   = {r_shift[WIDTH-2:0], 1'b0};
               w_bitcnt  = r_bitcnt - BCNT_W'(1);
            end
         end
         default: w_state = S_IDLE;
      endcase

      if (w_present) begin
         w_o       = w_bit;
         w_o_valid = 1'b1;
         w_expect  = 2'b00;
         if (w_hcnt_base == 2'd2) begin
            if (w_h_base == 2'b10 && w_bit) begin
               w_expect = 2'b10;
               w_cnt101 = r_cnt101 + CNT_W'(1);
            end else if (w_h_base == 2'b01 && !w_bit) begin
               w_expect = 2'b01;
               w_cnt010 = r_cnt010 + CNT_W'(1);
            end
         end
         w_h = {w_h_base[0], w_bit};
         if (w_hcnt_base != 2'd2) begin
            w_hcnt = w_hcnt_base + 2'd1;
         end
      end
   end

   assign load_ready = (r_state == S_IDLE);
   assign o          = r_o;
   assign o_valid    = r_o_valid;
   assign o_expect   = r_expect;
   assign done       = r_done;
   assign cnt101     = r_cnt101;
   assign cnt010     = r_cnt010;

endmodule

// File: tb/tb_pattern_stream_generator.sv
// Scoreboard bench for pattern_stream_generator: a behavioural detector model
// queues each word's bits and detector outputs; a negedge monitor pops them.
module tb_pattern_stream_generator;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       load_valid = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       hist_clr = 1'b0;

   logic       load_ready, o, o_valid, done;
   logic [1:0] o_expect;
   logic [7:0] cnt101, cnt010;

   logic       load_ready2, o2, o2_valid, done2;
   logic [1:0] o2_expect;
   logic [1:0] cnt101_2, cnt010_2;

   pattern_stream_generator #(.WIDTH(8), .CNT_W(8)) dut (
      .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .hist_clr(hist_clr), .o(o), .o_valid(o_valid),
      .o_expect(o_expect), .done(done), .cnt101(cnt101), .cnt010(cnt010));

   pattern_stream_generator #(.WIDTH(8), .CNT_W(2)) dut2 (
      .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready2),
      .load_data(load_data), .hist_clr(hist_clr), .o(o2), .o_valid(o2_valid),
      .o_expect(o2_expect), .done(done2), .cnt101(cnt101_2), .cnt010(cnt010_2));

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clock) cyc <= cyc + 1;

   typedef struct packed {
      logic       v;
      logic       o;
      logic       rdy;
      logic       dn;
      logic [1:0] e;
   } log_t;

   logic [2:0] sb[$];
   log_t       lg[$];
   logic [2:0] sb_exp;

   logic [1:0] m_h;
   int         m_hcnt, m_c101, m_c010;

   // Scoreboard consumer and per-cycle trace
   always @(negedge clock) begin
      lg.push_back({o_valid, o, load_ready, done, o_expect});
      if (o_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_bit: o_valid=1 with nothing queued at cyc %0d", cyc);
         end else begin
            sb_exp = sb.pop_front();
            if ({o, o_expect} !== sb_exp || {o2_valid, o2, o2_expect} !== {1'b1, sb_exp}) begin
               failures++;
               $display("FAIL stream_bit: cyc %0d got o=%b exp=%b (dut2 v=%b o=%b exp=%b) required o=%b exp=%b",
                        cyc, o, o_expect, o2_valid, o2, o2_expect, sb_exp[2], sb_exp[1:0]);
            end
         end
      end else if (o_valid === 1'b0) begin
         checks++;
         if (o_expect !== 2'b00 || o2_valid !== 1'b0 || o2_expect !== 2'b00) begin
            failures++;
            $display("FAIL idle_quiet: cyc %0d got exp=%b dut2 v=%b exp=%b required 00/0/00",
                     cyc, o_expect, o2_valid, o2_expect);
         end
      end
   end

   task automatic model_reset();
      m_h = 2'b00; m_hcnt = 0; m_c101 = 0; m_c010 = 0;
   endtask

   task automatic model_word(input logic [7:0] w);
      logic       b;
      logic [1:0] e;
      for (int i = 7; i >= 0; i--) begin
         b = w[i];
         e = 2'b00;
         if (m_hcnt == 2 && m_h == 2'b10 && b == 1'b1) begin e = 2'b10; m_c101++; end
         if (m_hcnt == 2 && m_h == 2'b01 && b == 1'b0) begin e = 2'b01; m_c010++; end
         sb.push_back({b, e});
         m_h = {m_h[0], b};
         if (m_hcnt < 2) m_hcnt++;
      end
   endtask

   task automatic reset_dut();
      load_valid = 1'b0; hist_clr = 1'b0; reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      sb.delete(); lg.delete();
      model_reset();
   endtask

   task automatic send_word(input logic [7:0] w, input bit hold, output int acc);
      int n = 0;
      load_data = w; load_valid = 1'b1; acc = -1;
      while (load_ready !== 1'b1 && n < 40) begin @(posedge clock); #1; n++; end
      if (load_ready !== 1'b1) begin
         checks++; failures++;
         $display("FAIL accept_timeout: load_ready=%b required 1", load_ready);
         load_valid = 1'b0;
      end else begin
         model_word(w);
         @(posedge clock); #1;
         acc = cyc;
         if (!hold) load_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      do begin @(negedge clock); n++; end while (done !== 1'b1 && n < 40);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL done_timeout: done=%b required 1 within 40 cycles", done);
      end
      #1;
   endtask

   function automatic int first_from(input int s);
      for (int i = s; i < lg.size(); i++) if (lg[i].v) return i;
      return s;
   endfunction

   task automatic test_reset();
      reset_dut();
      @(negedge clock);
      checks++;
      if ({o, o_valid, o_expect, done, load_ready} !== 6'b000001) begin
         failures++;
         $display("FAIL reset_outputs: o=%b v=%b exp=%b done=%b rdy=%b required 0 0 00 0 1",
                  o, o_valid, o_expect, done, load_ready);
      end
      checks++;
      if (cnt101 !== 8'd0 || cnt010 !== 8'd0 || cnt101_2 !== 2'd0 || cnt010_2 !== 2'd0) begin
         failures++;
         $display("FAIL reset_counters: got %0d %0d %0d %0d required 0 0 0 0",
                  cnt101, cnt010, cnt101_2, cnt010_2);
      end
   endtask

   task automatic test_basic();
      logic [7:0] w = 8'b10100110;
      logic [1:0] etab[8] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
      int a, f;
      reset_dut();
      send_word(w, 1'b0, a);
      wait_done();
      f = first_from(0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (lg[f+i].v !== 1'b1 || lg[f+i].o !== w[7-i] || lg[f+i].e !== etab[i] || lg[f+i].dn !== 1'b0) begin
            failures++;
            $display("FAIL basic_bit%0d: v=%b o=%b exp=%b done=%b required 1 %b %b 0",
                     i + 1, lg[f+i].v, lg[f+i].o, lg[f+i].e, lg[f+i].dn, w[7-i], etab[i]);
         end
      end
      checks++;
      if (lg[f+8].dn !== 1'b1 || lg[f+8].v !== 1'b0 || lg[f+8].rdy !== 1'b1) begin
         failures++;
         $display("FAIL basic_done_cycle: done=%b v=%b rdy=%b required 1 0 1",
                  lg[f+8].dn, lg[f+8].v, lg[f+8].rdy);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL basic_done_width: done=%b required 0", done);
      end
      checks++;
      if (cnt101 !== 8'd1 || cnt010 !== 8'd1 || sb.size() != 0) begin
         failures++;
         $display("FAIL basic_counters: cnt101=%0d cnt010=%0d queued=%0d required 1 1 0",
                  cnt101, cnt010, sb.size());
      end
   endtask

   task automatic test_back_to_back();
      int a1, a2, f;
      reset_dut();
      send_word(8'h05, 1'b1, a1);
      send_word(8'h00, 1'b0, a2);
      wait_done();
      checks++;
      if (a2 - a1 != 9) begin
         failures++;
         $display("FAIL b2b_period: got %0d required 9", a2 - a1);
      end
      f = first_from(0);
      checks++;
      if (lg[f+6].e !== 2'b01 || lg[f+7].e !== 2'b10 || lg[f+8].v !== 1'b0 ||
          lg[f+8].dn !== 1'b1 || lg[f+9].v !== 1'b1 || lg[f+9].e !== 2'b01) begin
         failures++;
         $display("FAIL b2b_boundary: b7=%b b8=%b gap v=%b done=%b w2b1 v=%b exp=%b required 01 10 0 1 1 01",
                  lg[f+6].e, lg[f+7].e, lg[f+8].v, lg[f+8].dn, lg[f+9].v, lg[f+9].e);
      end
      checks++;
      if (cnt010 !== 8'd2 || cnt101 !== 8'd1 || sb.size() != 0) begin
         failures++;
         $display("FAIL b2b_counters: cnt010=%0d cnt101=%0d queued=%0d required 2 1 0",
                  cnt010, cnt101, sb.size());
      end
   endtask

   task automatic test_hist_clr();
      int a, f1, f2;
      reset_dut();
      send_word(8'h05, 1'b0, a);
      wait_done();
      @(posedge clock); #1;
      hist_clr = 1'b1;
      @(posedge clock); #1;
      hist_clr = 1'b0;
      m_h = 2'b00; m_hcnt = 0;
      send_word(8'h00, 1'b0, a);
      wait_done();
      f1 = first_from(0);
      f2 = first_from(f1 + 8);
      checks++;
      if (lg[f2].v !== 1'b1 || lg[f2].e !== 2'b00) begin
         failures++;
         $display("FAIL clr_first_bit: v=%b exp=%b required 1 00", lg[f2].v, lg[f2].e);
      end
      checks++;
      if (cnt010 !== 8'd1 || cnt101 !== 8'd1) begin
         failures++;
         $display("FAIL clr_counters: cnt010=%0d cnt101=%0d required 1 1", cnt010, cnt101);
      end
   endtask

   task automatic test_continuous();
      logic [7:0] words[4] = '{8'h3C, 8'hA5, 8'h0F, 8'h96};
      int acc[4];
      int f, bad;
      reset_dut();
      for (int j = 0; j < 4; j++) begin
         send_word(words[j], j < 3, acc[j]);
         if (j > 0) begin
            checks++;
            if (acc[j] - acc[j-1] != 9) begin
               failures++;
               $display("FAIL cont_period%0d: got %0d required 9", j, acc[j] - acc[j-1]);
            end
         end
      end
      wait_done();
      f = first_from(0);
      for (int j = 0; j < 4; j++) begin
         bad = 0;
         for (int i = 0; i < 8; i++) if (lg[f+9*j+i].rdy !== 1'b0) bad++;
         if (lg[f+9*j+8].rdy !== 1'b1) bad++;
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL cont_ready_word%0d: %0d cycles with wrong load_ready", j, bad);
         end
      end
      checks++;
      if (sb.size() != 0 || cnt101 !== 8'(m_c101) || cnt010 !== 8'(m_c010)) begin
         failures++;
         $display("FAIL cont_totals: queued=%0d cnt101=%0d cnt010=%0d required 0 %0d %0d",
                  sb.size(), cnt101, cnt010, m_c101, m_c010);
      end
   endtask

   task automatic test_reset_mid();
      int a, f, seen;
      reset_dut();
      send_word(8'hAA, 1'b0, a);
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (o_valid !== 1'b1 || o !== 1'b0) begin
         failures++;
         $display("FAIL mid_bit4: v=%b o=%b required 1 0", o_valid, o);
      end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      sb.delete(); lg.delete();
      model_reset();
      @(negedge clock);
      checks++;
      if (o_valid !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0 || cnt101 !== 8'd0 || cnt010 !== 8'd0) begin
         failures++;
         $display("FAIL mid_after_reset: v=%b rdy=%b done=%b cnt=%0d/%0d required 0 1 0 0/0",
                  o_valid, load_ready, done, cnt101, cnt010);
      end
      seen = 0;
      repeat (12) begin
         @(negedge clock);
         if (done !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL mid_no_done: %0d done cycles required 0", seen);
      end
      send_word(8'hAA, 1'b0, a);
      wait_done();
      f = first_from(0);
      checks++;
      if (lg[f].e !== 2'b00 || lg[f+1].e !== 2'b00) begin
         failures++;
         $display("FAIL mid_history: b1=%b b2=%b required 00 00", lg[f].e, lg[f+1].e);
      end
   endtask

   task automatic test_wrap();
      int a;
      reset_dut();
      send_word(8'hAA, 1'b1, a);
      send_word(8'hAA, 1'b0, a);
      wait_done();
      checks++;
      if (cnt101 !== 8'd7 || cnt010 !== 8'd7) begin
         failures++;
         $display("FAIL wrap_wide: cnt101=%0d cnt010=%0d required 7 7", cnt101, cnt010);
      end
      checks++;
      if (cnt101_2 !== 2'd3 || cnt010_2 !== 2'd3) begin
         failures++;
         $display("FAIL wrap_narrow: cnt101=%0d cnt010=%0d required 3 3", cnt101_2, cnt010_2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_hist_clr();
      test_continuous();
      test_reset_mid();
      test_wrap();
      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
